if_id_reg: RTL and testbench

IF/ID pipeline register of the five-stage MIPS pipeline, downstream of the program counter and instruction memory. Each cycle it captures the fetched instruction and its PC+4 and presents them to the decode stage. It shares the `freeze` stall line with the PC so both stages hold together. It inserts a NOP bubble on `flush` when a taken branch or jump redirects fetch.

---
 rtl/if_id_reg.sv | 67 ++++++
 tb/tb_if_id_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register of the five-stage MIPS pipeline.
// Captures the fetched instruction and its PC+4 for the decode stage, holds on
// the shared freeze (stall) line and loads a NOP bubble on flush.
// Optional feature macro: IF_ID_PERF_CNT_EN adds clrCount, stallCount and
// flushCount (saturating stall/flush performance counters).
module if_id_reg #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             freeze,
  input  logic             flush,
  input  logic [WIDTH-1:0] pcPlus4In,
  input  logic [WIDTH-1:0] instrIn,
  output logic [WIDTH-1:0] pcPlus4Out,
  output logic [WIDTH-1:0] instrOut,
  output logic             validOut
`ifdef IF_ID_PERF_CNT_EN
  ,
  input  logic             clrCount,
  output logic [15:0]      stallCount,
  output logic [15:0]      flushCount
`endif
);

  // Pipeline register: flush beats freeze; an unknown control level falls
  // through both tests, so the register captures just as the PC does.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pcPlus4Out <= '0;
      instrOut   <= NOP;
      validOut   <= 1'b0;
    end else if (flush) begin
      pcPlus4Out <= pcPlus4In;
      instrOut   <= NOP;
      validOut   <= 1'b0;
    end else if (freeze) begin
      pcPlus4Out <= pcPlus4Out;
      instrOut   <= instrOut;
      validOut   <= validOut;
    end else begin
      pcPlus4Out <= pcPlus4In;
      instrOut   <= instrIn;
      validOut   <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Saturating stall/flush counters; a flush edge counts only as a flush.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stallCount <= '0;
      flushCount <= '0;
    end else if (clrCount) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (flush && (flushCount != '1))
        flushCount <= flushCount + 16'd1;
      if (!flush && freeze && (stallCount != '1))
        stallCount <= stallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed vector table, asynchronous reset
// sequences and a randomized run against a rule-level reference model.
module tb_if_id_reg;

  localparam logic [31:0] NOP_W = 32'h0000_0000;

  logic        clk;
  logic        resetN;
  logic        freeze;
  logic        flush;
  logic [31:0] pcPlus4In;
  logic [31:0] instrIn;
  logic [31:0] pcPlus4Out;
  logic [31:0] instrOut;
  logic        validOut;
  logic        clrCount;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  int unsigned n_checks;
  int unsigned n_fail;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  int unsigned m_stall;
  int unsigned m_flush;

  typedef struct {
    logic        frz;
    logic        fls;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    int unsigned e_stall;
    int unsigned e_flush;
  } vec_t;

  vec_t vecs[11];

`ifdef IF_ID_PERF_CNT_EN
  if_id_reg #(.WIDTH(32), .NOP(NOP_W)) dut (
    .clk(clk), .resetN(resetN), .freeze(freeze), .flush(flush),
    .pcPlus4In(pcPlus4In), .instrIn(instrIn),
    .pcPlus4Out(pcPlus4Out), .instrOut(instrOut), .validOut(validOut),
    .clrCount(clrCount), .stallCount(stallCount), .flushCount(flushCount)
  );
`else
  if_id_reg #(.WIDTH(32), .NOP(NOP_W)) dut (
    .clk(clk), .resetN(resetN), .freeze(freeze), .flush(flush),
    .pcPlus4In(pcPlus4In), .instrIn(instrIn),
    .pcPlus4Out(pcPlus4Out), .instrOut(instrOut), .validOut(validOut)
  );
  assign stallCount = '0;
  assign flushCount = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic e_valid);
    check({tag, " pcPlus4Out"}, pcPlus4Out, e_pc);
    check({tag, " instrOut"}, instrOut, e_instr);
    check({tag, " validOut"}, {31'd0, validOut}, {31'd0, e_valid});
  endtask

  task automatic check_counters(input string tag, input int unsigned e_stall,
                                input int unsigned e_flush);
`ifdef IF_ID_PERF_CNT_EN
    check({tag, " stallCount"}, {16'd0, stallCount}, e_stall);
    check({tag, " flushCount"}, {16'd0, flushCount}, e_flush);
`endif
  endtask

  // One clock of randomized traffic, checked against the rule-level model.
  task automatic step(input logic frz, input logic fls, input logic clr,
                      input logic [31:0] pc, input logic [31:0] instr);
    freeze    = frz;
    flush     = fls;
    clrCount  = clr;
    pcPlus4In = pc;
    instrIn   = instr;
    @(posedge clk);
    #1;
    if (fls) begin
      m_pc = pc; m_instr = NOP_W; m_valid = 1'b0;
    end else if (!frz) begin
      m_pc = pc; m_instr = instr; m_valid = 1'b1;
    end
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (fls) m_flush = (m_flush < 32'hFFFF) ? m_flush + 1 : 32'hFFFF;
      else if (frz) m_stall = (m_stall < 32'hFFFF) ? m_stall + 1 : 32'hFFFF;
    end
    check_outputs("rand", m_pc, m_instr, m_valid);
    check_counters("rand", m_stall, m_flush);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // frz fls pcIn instrIn | expected pc instr valid stall flush
    vecs[0]  = '{1'b0, 1'b0, 32'h04, 32'h2008_0005, 32'h04, 32'h2008_0005, 1'b1, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h08, 32'h1010_1014, 32'h04, 32'h2008_0005, 1'b1, 1, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h08, 32'h1010_1014, 32'h04, 32'h2008_0005, 1'b1, 2, 0};
    vecs[3]  = '{1'b1, 1'b0, 32'h08, 32'h1010_1014, 32'h04, 32'h2008_0005, 1'b1, 3, 0};
    vecs[4]  = '{1'b0, 1'b0, 32'h08, 32'h1010_1014, 32'h08, 32'h1010_1014, 1'b1, 3, 0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0C, 32'hAC01_0000, 32'h0C, NOP_W,         1'b0, 3, 1};
    vecs[6]  = '{1'b0, 1'b0, 32'h10, 32'h1234_5678, 32'h10, 32'h1234_5678, 1'b1, 3, 1};
    vecs[7]  = '{1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF, 32'h14, NOP_W,         1'b0, 3, 2};
    vecs[8]  = '{1'b0, 1'b1, 32'h18, 32'h0000_0001, 32'h18, NOP_W,         1'b0, 3, 3};
    vecs[9]  = '{1'b1, 1'b0, 32'h1C, 32'h0000_0002, 32'h18, NOP_W,         1'b0, 4, 3};
    vecs[10] = '{1'b0, 1'b0, 32'h20, 32'h8C22_0004, 32'h20, 32'h8C22_0004, 1'b1, 4, 3};

    // reset: assert asynchronously, hold two edges
    resetN    = 1'b1;
    freeze    = 1'b0;
    flush     = 1'b0;
    clrCount  = 1'b0;
    pcPlus4In = 32'hFFFF_FFF0;
    instrIn   = 32'hFFFF_FFFF;
    #2 resetN = 1'b0;
    #1;
    check_outputs("reset_async", 32'h0, NOP_W, 1'b0);
    check_counters("reset_async", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held", 32'h0, NOP_W, 1'b0);

    // release between edges with the first fetch already on the inputs
    pcPlus4In = vecs[0].pc;
    instrIn   = vecs[0].instr;
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check_outputs("reset_release_pre_edge", 32'h0, NOP_W, 1'b0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      freeze    = vecs[i].frz;
      flush     = vecs[i].fls;
      pcPlus4In = vecs[i].pc;
      instrIn   = vecs[i].instr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_valid);
      check_counters($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_flush);
    end

    // asynchronous reset in the middle of a stall
    freeze    = 1'b1;
    flush     = 1'b0;
    pcPlus4In = 32'h24;
    instrIn   = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
    check_outputs("stall_before_reset", 32'h20, 32'h8C22_0004, 1'b1);
    #3 resetN = 1'b0;
    #1;
    check_outputs("reset_mid_stall", 32'h0, NOP_W, 1'b0);
    check_counters("reset_mid_stall", 0, 0);
    @(posedge clk);
    #1;
    check_outputs("reset_mid_stall_edge", 32'h0, NOP_W, 1'b0);
    #2;
    freeze    = 1'b0;
    pcPlus4In = 32'h40;
    instrIn   = 32'h1111_2222;
    resetN    = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("resume_after_reset", 32'h40, 32'h1111_2222, 1'b1);
    check_counters("resume_after_reset", 0, 0);

    // asynchronous reset in the middle of a flush sequence
    flush = 1'b1;
    @(posedge clk);
    #1;
    #3 resetN = 1'b0;
    #1;
    check_outputs("reset_mid_flush", 32'h0, NOP_W, 1'b0);
    #1;
    flush     = 1'b0;
    pcPlus4In = 32'h44;
    instrIn   = 32'h3333_4444;
    resetN    = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("resume_after_flush_reset", 32'h44, 32'h3333_4444, 1'b1);

    // randomized run against the model
    m_pc = 32'h44; m_instr = 32'h3333_4444; m_valid = 1'b1;
    m_stall = 0; m_flush = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 40) == 0), $urandom, $urandom);
    end

`ifdef IF_ID_PERF_CNT_EN
    // saturation of the stall counter, then clear
    step(1'b0, 1'b0, 1'b1, 32'h50, 32'h5555_5555);
    freeze = 1'b1;
    flush  = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    check("stall_saturated", {16'd0, stallCount}, 32'h0000_FFFF);
    check("flush_during_saturation", {16'd0, flushCount}, 32'h0);
    check_outputs("hold_long_stall", 32'h50, 32'h5555_5555, 1'b1);
    freeze   = 1'b0;
    clrCount = 1'b1;
    @(posedge clk);
    #1;
    clrCount = 1'b0;
    check("stall_cleared", {16'd0, stallCount}, 32'h0);
    check("flush_cleared", {16'd0, flushCount}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
